// File: rtl/spsram_arb_ctrl.sv
// Two-port arbiter/sequencer in front of one single-port SRAM with a 1-cycle registered read.
// Port A (host) and port B (FIR engine) share the SRAM. Read data returns to its requester two cycles after the accept.
module spsram_arb_ctrl #(
  parameter int unsigned SRAM_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARB_MODE   = 0,
  localparam int unsigned ADDR_WIDTH = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iReqA,
  input  logic                  iWrnA,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iWrDtA,
  output logic                  oAckA,
  output logic                  oRdVldA,
  output logic [DATA_WIDTH-1:0] oRdDtA,
  input  logic                  iReqB,
  input  logic                  iWrnB,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iWrDtB,
  output logic                  oAckB,
  output logic                  oRdVldB,
  output logic [DATA_WIDTH-1:0] oRdDtB,
  output logic                  oCsn,
  output logic                  oWrn,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oWrDt,
  input  logic [DATA_WIDTH-1:0] iRdDt,
  output logic                  oErr
);

  typedef struct packed {
    logic vld;
    logic port;   // 0 = A, 1 = B
    logic oor;
  } tag_t;

  logic                  rrPtr;     // port favoured on contention: 0 = A, 1 = B
  tag_t                  tag1;
  logic                  rdOor;
  logic                  favorA;
  logic                  gntVld;
  logic                  gntPort;
  logic                  gntWrn;
  logic [ADDR_WIDTH-1:0] gntAddr;
  logic [DATA_WIDTH-1:0] gntWrDt;
  logic                  gntOor;

  assign favorA = (ARB_MODE == 1) || !rrPtr;
  assign oAckA  = !iRst && iReqA && (!iReqB || favorA);
  assign oAckB  = !iRst && iReqB && !(iReqA && favorA);

  // Select the winning request
  always_comb begin
    gntVld  = oAckA || oAckB;
    gntPort = oAckB;
    gntWrn  = oAckB ? iWrnB  : iWrnA;
    gntAddr = oAckB ? iAddrB : iAddrA;
    gntWrDt = oAckB ? iWrDtB : iWrDtA;
  end

  // Out-of-range addresses exist only when the depth does not fill the address space
  if ((32'(1) << ADDR_WIDTH) == SRAM_DEPTH) begin : gOorNone
    assign gntOor = 1'b0;
  end else begin : gOorCmp
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH+1)'(SRAM_DEPTH);
    assign gntOor = {1'b0, gntAddr} >= DepthW;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCsn    <= 1'b1;
      oWrn    <= 1'b1;
      oAddr   <= '0;
      oWrDt   <= '0;
      oErr    <= 1'b0;
      rrPtr   <= 1'b0;
      tag1    <= '0;
      oRdVldA <= 1'b0;
      oRdVldB <= 1'b0;
      rdOor   <= 1'b0;
    end else begin
      oCsn <= !(gntVld && !gntOor);
      if (gntVld) begin
        oWrn  <= gntWrn;
        oAddr <= gntAddr;
        oWrDt <= gntWrDt;
        rrPtr <= !gntPort;
      end
      if (gntVld && gntOor) begin
        oErr <= 1'b1;
      end
      tag1    <= '{vld: gntVld && gntWrn, port: gntPort, oor: gntOor};
      oRdVldA <= tag1.vld && !tag1.port;
      oRdVldB <= tag1.vld && tag1.port;
      rdOor   <= tag1.oor;
    end
  end

  // SRAM data arrives in the return cycle itself, so it is steered rather than registered
  assign oRdDtA = (oRdVldA && !rdOor) ? iRdDt : '0;
  assign oRdDtB = (oRdVldB && !rdOor) ? iRdDt : '0;

endmodule
